// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl_if
// Description : Bundles the three buses around the data-cache controller:
//               core load/store request/response, the cache data array
//               (MWR/MOE/Adr/MWD/CRD), and the main-memory req/ack channel.
//               slave  : used by dcache_ctrl (the controller itself).
//               master : used by the environment (core, array, memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_ctrl_if;
    // core side
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    // data array side
    logic        MWR;
    logic        MOE;
    logic [31:0] Adr;
    logic [31:0] MWD;
    logic [31:0] CRD;
    // main memory side
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata, CRD, mem_ack, mem_rdata,
        output cpu_rdata, cpu_ready, MWR, MOE, Adr, MWD,
               mem_req, mem_we, mem_adr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata, CRD, mem_ack, mem_rdata,
        input  cpu_rdata, cpu_ready, MWR, MOE, Adr, MWD,
               mem_req, mem_we, mem_adr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Request-side controller for a direct-mapped, one-word-line
//               data cache. Holds the valid/tag store, detects hits, refills
//               from main memory on a load miss and handles stores as
//               write-through / write-allocate. One request in flight.
// Ports       : clk, rst (sync, active high)
//               bus (dcache_ctrl_if.slave): core req/resp, array control,
//               memory req/ack channel.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int IDX_W = 7
) (
    input  wire logic    clk,
    input  wire logic    rst,
    dcache_ctrl_if.slave bus
);
    localparam int c_TAG_W = 30 - IDX_W;
    localparam int c_LINES = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM_RD = 3'd2,
        S_MEM_WR = 3'd3,
        S_FILL   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]        r_adr;
    logic               r_we;
    logic [31:0]        r_wdata;
    logic [31:0]        r_fill;    // data written into the array during FILL
    logic [31:0]        r_rdata;
    logic [c_LINES-1:0] r_valid;
    logic [c_TAG_W-1:0] r_tag [c_LINES];

    logic [IDX_W-1:0]   w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_hit;

    assign w_idx = r_adr[IDX_W+1:2];
    assign w_tag = r_adr[31:IDX_W+2];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.cpu_req) w_next = S_LOOKUP;
            // Stores always go to memory (write-through), hit or miss.
            S_LOOKUP: w_next = r_we ? S_MEM_WR : (w_hit ? S_RESP : S_MEM_RD);
            S_MEM_RD: if (bus.mem_ack) w_next = S_FILL;
            S_MEM_WR: if (bus.mem_ack) w_next = S_FILL;
            S_FILL:   w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_fill  <= '0;
            r_rdata <= '0;
            r_valid <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        r_adr   <= bus.cpu_adr;
                        r_we    <= bus.cpu_we;
                        r_wdata <= bus.cpu_wdata;
                    end
                end
                S_LOOKUP: begin
                    if (!r_we && w_hit) r_rdata <= bus.CRD;
                end
                S_MEM_RD: begin
                    if (bus.mem_ack) r_fill <= bus.mem_rdata;
                end
                S_MEM_WR: begin
                    // Write-allocate: the store data becomes the line data.
                    if (bus.mem_ack) r_fill <= r_wdata;
                end
                S_FILL: begin
                    r_valid[w_idx] <= 1'b1;
                    if (!r_we) r_rdata <= r_fill;
                end
                default: ;
            endcase
        end
    end

    // Tag contents are don't-care while the valid bit is clear, so no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_FILL) r_tag[w_idx] <= w_tag;
    end

    // Control outputs decode the state register only; data outputs are
    // registers, so nothing reaches the outputs combinationally.
    assign bus.MOE       = (r_state == S_LOOKUP);
    assign bus.MWR       = (r_state == S_FILL);
    assign bus.mem_req   = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign bus.mem_we    = (r_state == S_MEM_WR);
    assign bus.cpu_ready = (r_state == S_RESP);
    assign bus.Adr       = r_adr;
    assign bus.MWD       = r_fill;
    assign bus.mem_adr   = r_adr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_rdata = r_rdata;
endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl. Models the data array
//               (falling-edge write), a main memory responder, and a
//               reference cache/memory model built from the cache rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_ctrl_if bus();

    dcache_ctrl #(.IDX_W(7)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- environment: array and main memory ----------------
    logic [31:0] arr [128];
    always @(negedge clk) if (bus.MWR) arr[bus.Adr[8:2]] <= bus.MWD;
    assign bus.CRD = bus.MOE ? arr[bus.Adr[8:2]] : 32'h0;

    logic [31:0] phys_mem [logic [29:0]];

    function automatic logic [31:0] mem_init(input logic [29:0] w);
        return {w[15:0], ~w[15:0]} ^ 32'h3C3C_A5A5;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [29:0] w);
        return phys_mem.exists(w) ? phys_mem[w] : mem_init(w);
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [29:0]];
    bit          m_valid [128];
    logic [22:0] m_tag   [128];

    function automatic logic [31:0] ref_rd(input logic [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : mem_init(w);
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return m_valid[a[8:2]] && (m_tag[a[8:2]] == a[31:9]);
    endfunction

    task automatic model_update(input logic we, input logic [31:0] a, input logic [31:0] wd);
        m_valid[a[8:2]] = 1'b1;
        m_tag[a[8:2]]   = a[31:9];
        if (we) ref_mem[a[31:2]] = wd;
    endtask

    int total = 0;
    int bad   = 0;

    // ---------------- observations from one access ----------------
    int          ob_lat, ob_mreq, ob_mwr, ob_moe;
    logic [31:0] ob_rdata, ob_mwd, ob_madr, ob_mwdata;
    logic        ob_mwe, ob_unstable;

    // Issue one request, play memory with ack after k mem_req cycles,
    // and record what the controller did until cpu_ready (bounded).
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd, input int k);
        ob_lat = -1; ob_mreq = 0; ob_mwr = 0; ob_moe = 0; ob_unstable = 1'b0;
        ob_rdata = '0; ob_mwd = '0; ob_madr = '0; ob_mwdata = '0; ob_mwe = 1'b0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_adr = a; bus.cpu_wdata = wd;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.MOE) ob_moe++;
            if (bus.MWR) begin ob_mwr++; ob_mwd = bus.MWD; end
            if (bus.mem_req) begin
                if (ob_mreq == 0) begin
                    ob_madr = bus.mem_adr; ob_mwe = bus.mem_we; ob_mwdata = bus.mem_wdata;
                end else if (ob_madr !== bus.mem_adr || ob_mwe !== bus.mem_we ||
                             ob_mwdata !== bus.mem_wdata) begin
                    ob_unstable = 1'b1;
                end
                ob_mreq++;
                if (ob_mreq == k) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) phys_mem[bus.mem_adr[31:2]] = bus.mem_wdata;
                    else            bus.mem_rdata = phys_rd(bus.mem_adr[31:2]);
                end
            end
            if (bus.cpu_ready) begin
                ob_lat = n; ob_rdata = bus.cpu_rdata; bus.cpu_req = 1'b0;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if ({bus.cpu_ready, bus.MWR, bus.MOE, bus.mem_req, bus.mem_we} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000",
                {bus.cpu_ready, bus.MWR, bus.MOE, bus.mem_req, bus.mem_we}); end
        total++; if ({bus.cpu_rdata, bus.Adr, bus.MWD, bus.mem_adr, bus.mem_wdata} !== 160'b0) begin
            bad++; $display("FAIL reset_data got=%h want=0",
                {bus.cpu_rdata, bus.Adr, bus.MWD, bus.mem_adr, bus.mem_wdata}); end
        rst = 1'b0;
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    endtask

    task automatic test_load_miss();
        phys_mem[30'h40] = 32'hDEADBEEF; ref_mem[30'h40] = 32'hDEADBEEF;
        access(1'b0, 32'h0000_0100, 32'h0, 3);
        total++; if (ob_lat != 6) begin bad++; $display("FAIL miss_latency got=%0d want=6", ob_lat); end
        total++; if (ob_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL miss_rdata got=%h want=deadbeef", ob_rdata); end
        total++; if (ob_madr !== 32'h100 || ob_mwe !== 1'b0) begin
            bad++; $display("FAIL miss_mem_adr got=%h/%b want=00000100/0", ob_madr, ob_mwe); end
        total++; if (ob_mreq != 3 || ob_unstable) begin
            bad++; $display("FAIL miss_mem_req got=%0d/%b want=3/0", ob_mreq, ob_unstable); end
        total++; if (ob_mwr != 1 || ob_mwd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL miss_mwr got=%0d/%h want=1/deadbeef", ob_mwr, ob_mwd); end
        model_update(1'b0, 32'h100, 32'h0);
    endtask

    task automatic test_load_hit();
        access(1'b0, 32'h0000_0100, 32'h0, 1);
        total++; if (ob_lat != 2) begin bad++; $display("FAIL hit_latency got=%0d want=2", ob_lat); end
        total++; if (ob_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL hit_rdata got=%h want=deadbeef", ob_rdata); end
        total++; if (ob_mreq != 0 || ob_mwr != 0 || ob_moe != 1) begin
            bad++; $display("FAIL hit_activity got=req%0d/mwr%0d/moe%0d want=0/0/1", ob_mreq, ob_mwr, ob_moe); end
    endtask

    task automatic test_conflict();
        phys_mem[30'hC0] = 32'h0BADF00D; ref_mem[30'hC0] = 32'h0BADF00D;
        access(1'b0, 32'h0000_0300, 32'h0, 2);
        total++; if (ob_lat != 5 || ob_mreq != 2 || ob_madr !== 32'h300) begin
            bad++; $display("FAIL conflict_miss got=lat%0d/req%0d/%h want=5/2/00000300", ob_lat, ob_mreq, ob_madr); end
        total++; if (ob_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL conflict_rdata got=%h want=0badf00d", ob_rdata); end
        model_update(1'b0, 32'h300, 32'h0);
        access(1'b0, 32'h0000_0100, 32'h0, 1);
        total++; if (ob_lat != 4 || ob_mreq != 1 || ob_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL conflict_remiss got=lat%0d/req%0d/%h want=4/1/deadbeef", ob_lat, ob_mreq, ob_rdata); end
        model_update(1'b0, 32'h100, 32'h0);
    endtask

    task automatic test_store();
        access(1'b1, 32'h0000_0104, 32'h12345678, 1);
        total++; if (ob_lat != 4 || ob_mreq != 1) begin
            bad++; $display("FAIL store_timing got=lat%0d/req%0d want=4/1", ob_lat, ob_mreq); end
        total++; if (ob_mwe !== 1'b1 || ob_mwdata !== 32'h12345678 || ob_madr !== 32'h104) begin
            bad++; $display("FAIL store_mem got=%b/%h/%h want=1/12345678/00000104", ob_mwe, ob_mwdata, ob_madr); end
        total++; if (ob_mwr != 1 || ob_mwd !== 32'h12345678) begin
            bad++; $display("FAIL store_mwr got=%0d/%h want=1/12345678", ob_mwr, ob_mwd); end
        model_update(1'b1, 32'h104, 32'h12345678);
        access(1'b0, 32'h0000_0104, 32'h0, 1);
        total++; if (ob_lat != 2 || ob_mreq != 0 || ob_rdata !== 32'h12345678) begin
            bad++; $display("FAIL store_then_load got=lat%0d/req%0d/%h want=2/0/12345678", ob_lat, ob_mreq, ob_rdata); end
    endtask

    task automatic test_back_to_back();
        int rc = 0;
        logic [9:0] mask = '0;
        logic other = 1'b0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 32'h104;
        @(posedge clk);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (bus.cpu_ready) begin rc++; mask[n] = 1'b1; end
            if (bus.mem_req || bus.MWR) other = 1'b1;
            if (n == 6) bus.cpu_req = 1'b0;
        end
        total++; if (rc != 2 || mask !== 10'b0000100100 || other) begin
            bad++; $display("FAIL back_to_back got=cnt%0d/mask%b/%b want=2/0000100100/0", rc, mask, other); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        logic stray = 1'b0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 32'h500;
        @(posedge clk);
        for (int n = 0; n < 10 && seen < 2; n++) begin
            @(negedge clk);
            if (bus.mem_req) seen++;
        end
        total++; if (seen != 2) begin bad++; $display("FAIL rstmid_reach got=%0d want=2", seen); end
        rst = 1'b1; bus.cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({bus.mem_req, bus.MWR, bus.cpu_ready} !== 3'b000) begin
            bad++; $display("FAIL rstmid_after got=%b want=000", {bus.mem_req, bus.MWR, bus.cpu_ready}); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req || bus.MWR || bus.cpu_ready || bus.MOE) stray = 1'b1;
        end
        total++; if (stray) begin bad++; $display("FAIL rstmid_quiet got=1 want=0"); end
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
        access(1'b0, 32'h0000_0100, 32'h0, 2);
        total++; if (ob_lat != 5 || ob_mreq != 2 || ob_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rstmid_reload got=lat%0d/req%0d/%h want=5/2/deadbeef", ob_lat, ob_mreq, ob_rdata); end
        model_update(1'b0, 32'h100, 32'h0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 80; t++) begin
            logic        we  = 1'($urandom_range(0, 2) == 0);
            logic [31:0] a   = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            logic [31:0] wd  = $urandom;
            int          k   = $urandom_range(1, 4);
            bit          hit = ref_hit(a) && !we;
            logic [31:0] exp_d = we ? wd : ref_rd(a[31:2]);
            access(we, a, wd, k);
            total++; if (ob_lat != (hit ? 2 : 3 + k) || ob_mreq != (hit ? 0 : k) || ob_mwr != (hit ? 0 : 1)) begin
                bad++; $display("FAIL rand_flow[%0d] got=lat%0d/req%0d/mwr%0d want=%0d/%0d/%0d", t,
                    ob_lat, ob_mreq, ob_mwr, hit ? 2 : 3 + k, hit ? 0 : k, hit ? 0 : 1); end
            if (!we) begin
                total++; if (ob_rdata !== exp_d) begin
                    bad++; $display("FAIL rand_rdata[%0d] got=%h want=%h", t, ob_rdata, exp_d); end
            end
            if (!hit) begin
                total++; if (ob_madr[31:2] !== a[31:2] || ob_mwe !== we || ob_mwd !== exp_d || ob_unstable) begin
                    bad++; $display("FAIL rand_mem[%0d] got=%h/%b/%h/%b want=%h/%b/%h/0", t,
                        ob_madr, ob_mwe, ob_mwd, ob_unstable, {a[31:2], 2'b00}, we, exp_d); end
            end
            model_update(we, a, wd);
        end
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_adr = '0; bus.cpu_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        for (int i = 0; i < 128; i++) arr[i] = '0;
        test_reset();
        test_load_miss();
        test_load_hit();
        test_conflict();
        test_store();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Request-side controller for the direct-mapped data cache array. Sits between the core's load/store unit and the array (MWR/MOE/Adr/MWD/CRD), owns the valid/tag store, performs hit/miss detection, refills the array from main memory over a req/ack handshake on a read miss, and applies a write-through, write-allocate policy for stores. One request is in flight at a time; the core stalls until `cpu_ready`.

## Interface

- `IDX_W`, 7, index width; 2^IDX_W one-word lines; index = address[IDX_W+1:2], tag = address[31:IDX_W+2] (23 bits at default).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  request valid; held high until `cpu_ready`.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_adr`  in  32  byte address; bits [1:0] ignored (word access only).
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data, valid while `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `MWR`  out  1  array write enable (array writes on falling edge).
- `MOE`  out  1  array output enable.
- `Adr`  out  32  array address (latched request address).
- `MWD`  out  32  array write data.
- `CRD`  in  32  array read data (combinational from `Adr`/`MOE`).
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write.
- `mem_adr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_ack`  in  1  memory completion; sampled only while `mem_req`=1.
- `mem_rdata`  in  32  memory read data, valid with `mem_ack`.

## Operation

- States: IDLE, LOOKUP, MEM_RD, MEM_WR, FILL, RESP.
- IDLE: on `cpu_req`=1 latch `cpu_adr`, `cpu_we`, `cpu_wdata` -> LOOKUP.
- LOOKUP: `MOE`=1, `Adr`=latched addr; hit = valid[idx] && tag[idx]==addr tag.
  - load hit: register `CRD` into `cpu_rdata` -> RESP.
  - load miss -> MEM_RD. store (hit or miss) -> MEM_WR.
- MEM_RD: `mem_req`=1, `mem_we`=0, `mem_adr`=addr; on `mem_ack` capture `mem_rdata` -> FILL.
- MEM_WR: `mem_req`=1, `mem_we`=1, `mem_wdata`=store data; on `mem_ack` -> FILL.
- FILL: `MWR`=1, `Adr`=addr, `MWD`=captured fill data (load) or store data (store); at end of cycle set valid[idx]=1, tag[idx]=addr tag; load: `cpu_rdata`=fill data -> RESP.
- RESP: `cpu_ready`=1 for exactly one cycle -> IDLE. `cpu_req` ignored in RESP; a held `cpu_req` in the following IDLE cycle is a new request.
- Miss on a valid line overwrites tag/data (no writeback needed, write-through).
- `MOE`, `MWR`, `mem_req` are mutually exclusive and 0 outside their states; `MOE`=0 in all non-LOOKUP states.
- All outputs registered or decoded from state only; no combinational path from `cpu_*` or `mem_ack` to outputs.

## Timing

- Reset (synchronous): state IDLE; all valid bits cleared in one cycle; `cpu_ready`, `MWR`, `MOE`, `mem_req`, `mem_we`=0; `cpu_rdata`, `Adr`, `MWD`, `mem_adr`, `mem_wdata`=0.
- Request sampled in IDLE at edge N: load hit -> `cpu_ready` in cycle N+2.
- Load miss, `mem_ack` sampled at edge N+1+k (k>=1 cycles in MEM_RD): FILL at N+2+k, `cpu_ready` at N+3+k. Store: same timing.
- `mem_ack` high in the first MEM_RD/MEM_WR cycle is accepted (k=1). `mem_req` drops in the cycle after `mem_ack` sampled; `mem_adr`/`mem_we`/`mem_wdata` stable while `mem_req`=1.
- `mem_ack` while `mem_req`=0 ignored.
- FILL `MWR`/`Adr`/`MWD` stable full cycle so the falling-edge write lands mid-cycle; an immediately following request to the same address hits with new data.
- Reset mid-operation: in-flight request discarded, `mem_req`=0 next cycle, no `MWR`, no `cpu_ready`; late `mem_ack` ignored.

## Test plan

- Reset, load 0x0000_0100; ack 3 cycles after `mem_req` with 0xDEADBEEF -> `mem_adr`=0x100, one `MWR` pulse with `MWD`=0xDEADBEEF, `cpu_ready` with `cpu_rdata`=0xDEADBEEF.
- Reload 0x0000_0100 -> no `mem_req`, `MOE` in LOOKUP, `cpu_ready` exactly 2 cycles after acceptance, `cpu_rdata`=0xDEADBEEF.
- Load 0x0000_0300 (same index 0x40, different tag), ack 0x0BADF00D -> miss, refill; then load 0x100 -> misses again.
- Store 0x12345678 to 0x0000_0104 with `mem_ack` in the first MEM_WR cycle -> `mem_we`=1, `mem_wdata`=0x12345678, `MWR` pulse; following load of 0x104 hits, returns 0x12345678.
- Assert `rst` during MEM_RD wait, then pulse `mem_ack` -> `mem_req`=0 after reset edge, no `MWR`/`cpu_ready`; load 0x100 afterwards misses (valid cleared).
- Hold `cpu_req` high across RESP -> request re-accepted only in next IDLE; exactly one `cpu_ready` per accepted request.
